// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates one mechanical key press/release waveform on key_n
// (active-low, idle high) for each accepted press_req.
// Optional feature macro: KEY_BOUNCE_GEN_BOUNCE_EN. When defined, the press and
// release phases bounce with LFSR-timed toggles; when undefined, each bounce
// phase is a single clean cycle and the LFSR is not built.
module key_bounce_gen #(
    parameter int          BOUNCE_TOGGLES = 4,
    parameter int          GAP_BITS       = 4,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        press_req,
    input  logic [19:0] hold_cycles,
    output logic        key_n,
    output logic        busy,
    output logic        done
);

    // Refuse to elaborate with an unusable parameter set.
    if ((BOUNCE_TOGGLES < 2) || (BOUNCE_TOGGLES > 14) || ((BOUNCE_TOGGLES % 2) != 0) ||
        (GAP_BITS < 1) || (GAP_BITS > 8) || (SEED == 16'h0000)) begin : g_bad_params
        $error("key_bounce_gen: illegal parameter set");
    end

    localparam logic [19:0] HOLD_ONE = 20'd1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE
    } state_t;

    state_t      state_q;
    logic        key_q;
    logic        busy_q;
    logic        done_q;
    logic [19:0] hold_cnt_q;
    logic [19:0] hold_load;

    // A zero hold request still produces a one-cycle stable-low segment.
    assign hold_load = (hold_cycles == 20'd0) ? HOLD_ONE : hold_cycles;

`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    localparam int             GW      = GAP_BITS + 1;
    localparam logic [3:0]     TOGGLES = 4'(BOUNCE_TOGGLES);
    localparam logic [GW-1:0]  GAP_ONE = GW'(1);

    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_load;
    logic [3:0]    tog_cnt_q;

    // Galois step for x^16+x^14+x^13+x^11+1, shifting towards bit 0.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    // Gap length is 1..2^GAP_BITS cycles, drawn from the current LFSR value.
    assign gap_load = GW'(lfsr_q[GAP_BITS-1:0]) + GAP_ONE;

    // Free-running LFSR, advancing every cycle regardless of state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Waveform sequencer with registered key_n/busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_cnt_q <= 20'd0;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
            gap_cnt_q  <= '0;
            tog_cnt_q  <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_req) begin
                        hold_cnt_q <= hold_load;
                        busy_q     <= 1'b1;
                        state_q    <= PRESS_BOUNCE;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                        gap_cnt_q  <= gap_load;
                        tog_cnt_q  <= 4'd0;
`endif
                    end
                end
                PRESS_BOUNCE: begin
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                    if (gap_cnt_q == GAP_ONE) begin
                        gap_cnt_q <= gap_load;
                        if (tog_cnt_q < TOGGLES) begin
                            key_q     <= ~key_q;
                            tog_cnt_q <= tog_cnt_q + 4'd1;
                        end else begin
                            // Bounce finished: settle low for the hold.
                            key_q   <= 1'b0;
                            state_q <= HOLD;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
`else
                    key_q   <= 1'b0;
                    state_q <= HOLD;
`endif
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_ONE) begin
                        // Leaving hold counts as the first release transition,
                        // which keeps the stable-low segment exactly hold long.
                        key_q      <= 1'b1;
                        hold_cnt_q <= 20'd0;
                        state_q    <= RELEASE_BOUNCE;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                        gap_cnt_q  <= gap_load;
                        tog_cnt_q  <= 4'd1;
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                    end
                end
                RELEASE_BOUNCE: begin
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
                    if (gap_cnt_q == GAP_ONE) begin
                        gap_cnt_q <= gap_load;
                        if (tog_cnt_q < TOGGLES) begin
                            key_q     <= ~key_q;
                            tog_cnt_q <= tog_cnt_q + 4'd1;
                        end else begin
                            key_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
`else
                    key_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign key_n = key_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: randomized and directed stimulus for key_bounce_gen,
// checked every cycle against a waveform-level reference model.
module tb_key_bounce_gen;

    localparam int          T_CFG    = 4;
    localparam int          GAP_BITS = 4;
    localparam logic [15:0] SEED     = 16'hACE1;
`ifdef KEY_BOUNCE_GEN_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif
    localparam int          T_EFF    = BOUNCE ? T_CFG : 0;
    localparam logic [15:0] GMASK    = 16'((1 << GAP_BITS) - 1);
    localparam int          DEB_MAX  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        press_req = 1'b0;
    logic [19:0] hold_cycles = 20'd0;
    logic        key_n;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    key_bounce_gen #(
        .BOUNCE_TOGGLES (T_CFG),
        .GAP_BITS       (GAP_BITS),
        .SEED           (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press_req   (press_req),
        .hold_cycles (hold_cycles),
        .key_n       (key_n),
        .busy        (busy),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: future {key_n,busy,done} per cycle for the current waveform.
    logic [2:0]  exp_q[$];
    logic [2:0]  exp_o = 3'b100;
    logic [15:0] lf = SEED;
    logic [15:0] acc_lf = SEED;
    int          acc_cyc = 0;

    // Observation counters.
    int   cyc = 0;
    int   falls = 0;
    int   rises = 0;
    int   dones = 0;
    int   low_run = 0;
    int   low_runs[$];
    int   first_fall_cyc = -1;
    logic prev_key = 1'b1;
    logic deb_level = 1'b1;
    int   deb_cnt = 0;
    int   deb_pulses = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
        end
        return r;
    endfunction

    function automatic int gap_of(input logic [15:0] v);
        return BOUNCE ? (1 + int'(v & GMASK)) : 1;
    endfunction

    function automatic void push_n(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endfunction

    // Lay out the whole waveform: transitions at gap expiries, hold, release.
    function automatic void gen_wave(input logic [15:0] l0, input logic [19:0] h);
        logic [15:0] l;
        logic        k;
        int          g;
        int          n;
        l = l0;
        k = 1'b1;
        for (int i = 0; i <= T_EFF; i++) begin
            g = gap_of(l);
            push_n({k, 2'b10}, g - 1);
            k = (i < T_EFF) ? ~k : 1'b0;
            push_n({k, 2'b10}, 1);
            l = lfsr_adv(l, g);
        end
        n = (h == 20'd0) ? 1 : int'(h);
        push_n(3'b010, n - 1);
        l = lfsr_adv(l, n);
        k = 1'b1;
        push_n(3'b110, 1);
        for (int i = 1; i < T_EFF; i++) begin
            g = gap_of(l);
            push_n({k, 2'b10}, g - 1);
            k = ~k;
            push_n({k, 2'b10}, 1);
            l = lfsr_adv(l, g);
        end
        g = gap_of(l);
        push_n({k, 2'b10}, g - 1);
        push_n(3'b101, 1);
    endfunction

    function automatic void model_step();
        logic accept;
        if (!rst_n) begin
            exp_q.delete();
            lf    = SEED;
            exp_o = 3'b100;
        end else begin
            accept = (exp_q.size() == 0) && press_req;
            if (exp_q.size() > 0) exp_o = exp_q.pop_front();
            else                  exp_o = 3'b100;
            if (accept) begin
                acc_lf  = lf;
                acc_cyc = cyc;
                gen_wave(lf, hold_cycles);
                exp_o = 3'b110;
            end
            lf = lfsr_adv(lf, 1);
        end
    endfunction

    function automatic void check_cycle();
        cyc++;
        checks++;
        if ({key_n, busy, done} !== exp_o) begin
            errors++;
            $display("FAIL cycle_check cyc=%0d key_n/busy/done got %b%b%b expected %b",
                     cyc, key_n, busy, done, exp_o);
        end
        if (prev_key && !key_n) begin
            falls++;
            if (first_fall_cyc < 0) first_fall_cyc = cyc;
        end
        if (!key_n) begin
            low_run++;
        end else begin
            if (!prev_key) begin
                rises++;
                low_runs.push_back(low_run);
            end
            low_run = 0;
        end
        if (done) dones++;
        // Counter-style debouncer with a 20-cycle stability requirement.
        if (key_n != deb_level) begin
            deb_cnt++;
            if (deb_cnt >= DEB_MAX) begin
                deb_level = key_n;
                deb_cnt   = 0;
                if (!key_n) deb_pulses++;
            end
        end else begin
            deb_cnt = 0;
        end
        prev_key = key_n;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout got no done after %0d cycles expected done", name, budget);
        end
    endtask

    // One full waveform with literal expectations on its shape.
    task automatic run_wave(input string name, input logic [19:0] h, input bit check_deb);
        int f0, r0, d0, p0, want_hold, hold_run;
        f0 = falls; r0 = rises; d0 = dones; p0 = deb_pulses;
        first_fall_cyc = -1;
        hold_cycles = h;
        press_req = 1'b1;
        tick();
        press_req = 1'b0;
        hold_cycles = 20'($urandom_range(0, 1000));
        wait_done(name, 3000);
        repeat (30) tick();
        want_hold = (h == 20'd0) ? 1 : int'(h);
        hold_run = (low_runs.size() > r0 + T_EFF / 2) ? low_runs[r0 + T_EFF / 2] : -1;
        check_eq({name, "_falls"}, falls - f0, T_EFF + 1);
        check_eq({name, "_rises"}, rises - r0, T_EFF + 1);
        check_eq({name, "_dones"}, dones - d0, 1);
        check_eq({name, "_hold_low_run"}, hold_run, want_hold);
        check_eq({name, "_first_fall_cyc"}, first_fall_cyc, acc_cyc + 1 + gap_of(acc_lf));
        if (check_deb) check_eq({name, "_debounced_pulses"}, deb_pulses - p0, 1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("reset_state", int'({key_n, busy, done}), 4);
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("idle_state", int'({key_n, busy, done}), 4);

        run_wave("hold100", 20'd100, 1'b1);
        run_wave("hold0", 20'd0, 1'b0);
        run_wave("hold50", 20'd50, 1'b1);
        run_wave("hold200_debounce", 20'd200, 1'b1);

        // press_req held every cycle while busy: only one waveform.
        d0 = dones;
        hold_cycles = 20'd40;
        press_req = 1'b1;
        tick();
        for (int i = 0; i < 3000 && !done; i++) begin
            press_req = busy;
            hold_cycles = 20'($urandom_range(0, 500));
            tick();
        end
        press_req = 1'b0;
        repeat (20) tick();
        check_eq("busy_spam_dones", dones - d0, 1);

        // press_req in the done cycle starts the next waveform immediately.
        d0 = dones;
        hold_cycles = 20'd5;
        press_req = 1'b1;
        tick();
        press_req = 1'b0;
        wait_done("b2b_first", 3000);
        hold_cycles = 20'd7;
        press_req = 1'b1;
        tick();
        press_req = 1'b0;
        check_eq("b2b_busy", int'(busy), 1);
        wait_done("b2b_second", 3000);
        tick();
        check_eq("b2b_dones", dones - d0, 2);

        // Reset in the middle of HOLD aborts cleanly.
        hold_cycles = 20'd300;
        press_req = 1'b1;
        tick();
        press_req = 1'b0;
        repeat (150) tick();
        check_eq("hold_key_low", int'(key_n), 0);
        rst_n = 1'b0;
        tick();
        check_eq("mid_reset_outputs", int'({key_n, busy, done}), 4);
        rst_n = 1'b1;
        d0 = dones;
        repeat (40) tick();
        check_eq("mid_reset_no_done", dones - d0, 0);
        run_wave("after_reset", 20'd12, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            press_req = ($urandom_range(0, 7) == 0);
            hold_cycles = 20'($urandom_range(0, 40));
            tick();
        end
        rst_n = 1'b1;
        press_req = 1'b0;
        repeat (400) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
